hash_chain_accum: RTL and testbench

Parametrised feed-forward and chaining stage for SHA-2 family cores. It adds each compressed block's working variables to the running chaining value, word by word, modulo 2^WORD_W. It processes LANES words per cycle and holds the chaining value across the blocks of a multi-block message. On the last block it presents the digest, big-endian word order, through a valid/ready handshake. It sits between the compression-round engine and the digest output interface, replacing the fixed 256-bit single-cycle final-add stage.

---
 rtl/hash_chain_accum.sv | 151 +++++++++++++++
 tb/tb_hash_chain_accum.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hash_chain_accum.sv
// Feed-forward / chaining stage for SHA-2 cores: adds each compressed block's
// working variables into the chaining value LANES words per cycle, then presents the digest.
module hash_chain_accum #(
    parameter int WORD_W    = 32,
    parameter int NUM_WORDS = 8,
    parameter int LANES     = 2,
    parameter logic [WORD_W*NUM_WORDS-1:0] IV = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    }
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_msg,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic                        in_last,
    input  logic [WORD_W*NUM_WORDS-1:0] in_hash,
    output logic [WORD_W*NUM_WORDS-1:0] chain_hash,
    output logic [WORD_W*NUM_WORDS-1:0] digest,
    output logic                        digest_valid,
    input  logic                        digest_ready,
    output logic                        busy,
    output logic [1:0]                  fsm_state
);

    // Handshake: a block transfers on a rising edge where in_valid && in_ready;
    // the digest transfers on a rising edge where digest_valid && digest_ready.
    // Once raised, digest_valid and digest hold until that transfer or an abort.

    localparam int HW = WORD_W * NUM_WORDS;
    localparam int N  = NUM_WORDS / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [HW-1:0]   chain;
    logic [HW-1:0]   chain_sum;
    logic [HW-1:0]   operand;
    logic [HW-1:0]   iv_chain;
    logic            last_q;
    logic [CW-1:0]   cnt;
    logic            cnt_last;

    // Chain is LSW-first (H0 in word 0); IV and digest carry H0 at the MSBs.
    function automatic logic [HW-1:0] word_swap(input logic [HW-1:0] x);
        logic [HW-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            r[k*WORD_W +: WORD_W] = x[(NUM_WORDS-1-k)*WORD_W +: WORD_W];
        end
        return r;
    endfunction

    assign iv_chain   = word_swap(IV);
    assign cnt_last   = (int'(cnt) == N - 1);
    assign in_ready   = (state == IDLE) && !start_msg;
    assign chain_hash = chain;
    assign fsm_state  = state;

    // Only the lane group selected by cnt is updated; carries out of each word are dropped.
    always_comb begin
        chain_sum = chain;
        for (int i = 0; i < NUM_WORDS; i++) begin
            if (i / LANES == int'(cnt)) begin
                chain_sum[i*WORD_W +: WORD_W] = chain[i*WORD_W +: WORD_W]
                                              + operand[i*WORD_W +: WORD_W];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (!start_msg && in_valid) next_state = ADD;
            end
            ADD: begin
                if (start_msg)     next_state = IDLE;
                else if (cnt_last) next_state = last_q ? HOLD : IDLE;
            end
            HOLD: begin
                if (start_msg)                         next_state = IDLE;
                else if (digest_valid && digest_ready) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            busy  <= 1'b0;
        end else begin
            state <= next_state;
            busy  <= (next_state != IDLE);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            chain        <= iv_chain;
            operand      <= '0;
            last_q       <= 1'b0;
            cnt          <= '0;
            digest       <= '0;
            digest_valid <= 1'b0;
        end else if (start_msg) begin
            // Abort or fresh message: partial sums are discarded with the reload.
            chain        <= iv_chain;
            cnt          <= '0;
            digest_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        operand <= in_hash;
                        last_q  <= in_last;
                        cnt     <= '0;
                    end
                end
                ADD: begin
                    chain <= chain_sum;
                    if (cnt_last) begin
                        cnt <= '0;
                        if (last_q) begin
                            digest       <= word_swap(chain_sum);
                            digest_valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (digest_ready) begin
                        digest_valid <= 1'b0;
                        chain        <= iv_chain;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_hash_chain_accum.sv
// Directed bench for hash_chain_accum: default, 64-bit single-cycle and
// single-lane configurations, with a digest scoreboard queue.
module tb_hash_chain_accum;

    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    localparam logic [255:0] IV256 = {
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };
    localparam logic [511:0] IV512 = {
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179
    };

    // default configuration
    logic         start_msg, in_valid, in_last, digest_ready;
    logic [255:0] in_hash;
    logic         in_ready, digest_valid, busy;
    logic [255:0] chain_hash, digest;
    logic [1:0]   fsm_state;

    // 64-bit words, 8 lanes
    logic         start_msg_w, in_valid_w, in_last_w, digest_ready_w;
    logic [511:0] in_hash_w;
    logic         in_ready_w, digest_valid_w, busy_w;
    logic [511:0] chain_hash_w, digest_w;
    logic [1:0]   fsm_state_w;

    // 32-bit words, 1 lane
    logic         start_msg_l, in_valid_l, in_last_l, digest_ready_l;
    logic [255:0] in_hash_l;
    logic         in_ready_l, digest_valid_l, busy_l;
    logic [255:0] chain_hash_l, digest_l;
    logic [1:0]   fsm_state_l;

    hash_chain_accum u_dut (
        .clock(clock), .reset(reset), .start_msg(start_msg), .in_valid(in_valid),
        .in_ready(in_ready), .in_last(in_last), .in_hash(in_hash), .chain_hash(chain_hash),
        .digest(digest), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .busy(busy), .fsm_state(fsm_state)
    );

    hash_chain_accum #(.WORD_W(64), .NUM_WORDS(8), .LANES(8), .IV(IV512)) u_dut_w (
        .clock(clock), .reset(reset), .start_msg(start_msg_w), .in_valid(in_valid_w),
        .in_ready(in_ready_w), .in_last(in_last_w), .in_hash(in_hash_w), .chain_hash(chain_hash_w),
        .digest(digest_w), .digest_valid(digest_valid_w), .digest_ready(digest_ready_w),
        .busy(busy_w), .fsm_state(fsm_state_w)
    );

    hash_chain_accum #(.LANES(1)) u_dut_l (
        .clock(clock), .reset(reset), .start_msg(start_msg_l), .in_valid(in_valid_l),
        .in_ready(in_ready_l), .in_last(in_last_l), .in_hash(in_hash_l), .chain_hash(chain_hash_l),
        .digest(digest_l), .digest_valid(digest_valid_l), .digest_ready(digest_ready_l),
        .busy(busy_l), .fsm_state(fsm_state_l)
    );

    int tests_run = 0;
    int tests_failed = 0;
    logic [511:0] exp_q[$];

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] swap_words(input logic [511:0] x, input int w, input int n);
        logic [511:0] r;
        r = '0;
        for (int k = 0; k < n; k++)
            for (int b = 0; b < w; b++)
                r[k*w+b] = x[(n-1-k)*w+b];
        return r;
    endfunction

    function automatic logic [511:0] add_model(input logic [511:0] a, input logic [511:0] b,
                                               input int w, input int n);
        logic [511:0] r;
        logic [63:0]  wa, wb, s;
        r = '0;
        for (int k = 0; k < n; k++) begin
            wa = 64'(a >> (k*w));
            wb = 64'(b >> (k*w));
            if (w == 32) begin
                wa[63:32] = '0;
                wb[63:32] = '0;
            end
            s = wa + wb;
            if (w == 32) s[63:32] = '0;
            r = r | (512'(s) << (k*w));
        end
        return r;
    endfunction

    function automatic logic [255:0] rand_block();
        logic [255:0] r;
        for (int k = 0; k < 8; k++) r[k*32 +: 32] = $urandom_range(32'hffff_ffff, 0);
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send0(input logic [255:0] h, input logic last);
        int c = 0;
        while (!in_ready && c < 50) begin
            tick();
            c++;
        end
        check("send_ready", 512'(in_ready), 512'(1));
        in_hash  = h;
        in_last  = last;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_digest0(input int exp_lat, input string tag);
        int c = 0;
        logic [511:0] e;
        while (!digest_valid && c < 30) begin
            tick();
            c++;
        end
        check({tag, "_latency"}, 512'(c), 512'(exp_lat));
        check({tag, "_queue"}, 512'(exp_q.size()), 512'(1));
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_digest"}, 512'(digest), e);
        end
    endtask

    task automatic handshake0(input string tag);
        digest_ready = 1'b1;
        tick();
        digest_ready = 1'b0;
        check({tag, "_dv_clear"}, 512'(digest_valid), 512'(0));
        check({tag, "_idle"}, 512'(fsm_state), 512'(0));
        check({tag, "_chain_iv"}, 512'(chain_hash), swap_words(512'(IV256), 32, 8));
    endtask

    initial begin
        logic [255:0] h, iv_chain, ones;
        logic [255:0] wrap_digest;
        logic [511:0] e;
        int c, seen;

        iv_chain = 256'(swap_words(512'(IV256), 32, 8));
        ones = {8{32'h1}};
        wrap_digest = {32'h6a09e666, 32'hbb67ae84, 32'h3c6ef371, 32'ha54ff539,
                       32'h510e527e, 32'h9b05688b, 32'h1f83d9aa, 32'h5be0cd18};

        // clock / reset
        reset = 1'b1;
        {start_msg, in_valid, in_last, digest_ready} = '0;
        {start_msg_w, in_valid_w, in_last_w, digest_ready_w} = '0;
        {start_msg_l, in_valid_l, in_last_l, digest_ready_l} = '0;
        in_hash = '0; in_hash_w = '0; in_hash_l = '0;
        tick();
        tick();
        reset = 1'b0;
        tick();

        check("rst_state", 512'(fsm_state), 512'(0));
        check("rst_in_ready", 512'(in_ready), 512'(1));
        check("rst_busy", 512'(busy), 512'(0));
        check("rst_dv", 512'(digest_valid), 512'(0));
        check("rst_digest", 512'(digest), 512'(0));
        check("rst_chain", 512'(chain_hash), 512'(iv_chain));

        // zero block, last: digest equals IV
        exp_q.push_back(512'({32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                              32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19}));
        send0('0, 1'b1);
        check("add_busy", 512'(busy), 512'(1));
        wait_digest0(4, "zero");
        check("hold_state", 512'(fsm_state), 512'(2));
        check("hold_busy", 512'(busy), 512'(1));
        handshake0("zero_hs");

        // wrap-around with backpressure; a competing block is offered throughout
        exp_q.push_back(512'(wrap_digest));
        send0('1, 1'b1);
        wait_digest0(4, "wrap");
        in_hash  = rand_block();
        in_last  = 1'b1;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_dv", 512'(digest_valid), 512'(1));
            check("bp_digest", 512'(digest), 512'(wrap_digest));
            check("bp_in_ready", 512'(in_ready), 512'(0));
        end
        in_valid = 1'b0;
        handshake0("wrap_hs");
        tick();
        check("bp_no_accept", 512'(busy), 512'(0));

        // two-block message
        send0(ones, 1'b0);
        c = 0;
        while (!in_ready && c < 30) begin
            tick();
            c++;
        end
        check("blk1_ready_lat", 512'(c), 512'(4));
        check("blk1_chain", 512'(chain_hash), add_model(512'(iv_chain), 512'(ones), 32, 8));
        e = add_model(add_model(512'(iv_chain), 512'(ones), 32, 8), 512'(ones), 32, 8);
        exp_q.push_back(swap_words(e, 32, 8));
        send0(ones, 1'b1);
        wait_digest0(4, "blk2");
        handshake0("blk2_hs");

        // abort during ADD cycle j=2
        send0(rand_block(), 1'b1);
        tick();
        tick();
        start_msg = 1'b1;
        #1;
        check("abort_in_ready", 512'(in_ready), 512'(0));
        tick();
        start_msg = 1'b0;
        check("abort_state", 512'(fsm_state), 512'(0));
        check("abort_chain", 512'(chain_hash), 512'(iv_chain));
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (digest_valid) seen++;
        end
        check("abort_no_digest", 512'(seen), 512'(0));

        // asynchronous reset while holding a digest
        h = rand_block();
        exp_q.push_back(swap_words(add_model(512'(iv_chain), 512'(h), 32, 8), 32, 8));
        send0(h, 1'b1);
        wait_digest0(4, "prerst");
        #2;
        reset = 1'b1;
        #1;
        check("arst_dv", 512'(digest_valid), 512'(0));
        check("arst_state", 512'(fsm_state), 512'(0));
        check("arst_digest", 512'(digest), 512'(0));
        check("arst_chain", 512'(chain_hash), 512'(iv_chain));
        #1;
        reset = 1'b0;
        tick();

        // 64-bit words, all lanes in one cycle
        e = add_model(swap_words(IV512, 64, 8), {512{1'b1}}, 64, 8);
        exp_q.push_back(swap_words(e, 64, 8));
        in_hash_w  = '1;
        in_last_w  = 1'b1;
        in_valid_w = 1'b1;
        tick();
        in_valid_w = 1'b0;
        c = 0;
        while (!digest_valid_w && c < 30) begin
            tick();
            c++;
        end
        check("w64_latency", 512'(c), 512'(1));
        check("w64_queue", 512'(exp_q.size()), 512'(1));
        if (exp_q.size() > 0) check("w64_digest", digest_w, exp_q.pop_front());
        check("w64_word0", 512'(digest_w[511:448]), 512'(64'h6a09e667f3bcc907));
        digest_ready_w = 1'b1;
        tick();
        digest_ready_w = 1'b0;
        check("w64_dv_clear", 512'(digest_valid_w), 512'(0));

        // single lane: eight add cycles
        h = rand_block();
        exp_q.push_back(swap_words(add_model(512'(iv_chain), 512'(h), 32, 8), 32, 8));
        in_hash_l  = h;
        in_last_l  = 1'b1;
        in_valid_l = 1'b1;
        tick();
        in_valid_l = 1'b0;
        c = 0;
        while (!digest_valid_l && c < 30) begin
            tick();
            c++;
        end
        check("l1_latency", 512'(c), 512'(8));
        check("l1_queue", 512'(exp_q.size()), 512'(1));
        if (exp_q.size() > 0) check("l1_digest", 512'(digest_l), exp_q.pop_front());
        digest_ready_l = 1'b1;
        tick();
        digest_ready_l = 1'b0;
        check("l1_chain_iv", 512'(chain_hash_l), 512'(iv_chain));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
